// File: rtl/irq_pkg.sv
// Shared types and default sizing for the external interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int unsigned NSRC_DEF    = 4;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned HOLDOFF_DEF = 2;
  localparam int unsigned TCNT_W      = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line two-flop synchronizer followed by a third flop for rising-edge detection.
module irq_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

endmodule

// File: rtl/ext_irq_ctrl.sv
// Requester side of the ExtIRQ/ExtIAck handshake: latches source edges as pending,
// presents the lowest-index enabled one and enforces an idle gap after each ack.
module ext_irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NSRC    = NSRC_DEF,
  parameter int unsigned IDW     = $clog2(NSRC),
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned HOLDOFF = HOLDOFF_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic [NSRC-1:0] irq_en,
  output logic            ExtIRQ,
  input  logic            ExtIAck,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic            busy,
  output logic            timeout_flag,
  input  logic            timeout_clr
);

  localparam int unsigned HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HCW-1:0]    HOLD_INIT = HCW'(HOLDOFF - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;
  localparam logic [TCNT_W:0]   TCNT_HIT  = (TCNT_W + 1)'(TIMEOUT);

  state_t            state;
  logic [TCNT_W-1:0] tcnt;
  logic [HCW-1:0]    hcnt;

  logic [NSRC-1:0]   rise_c;
  logic [NSRC-1:0]   ack_clr_c;
  logic              any_c;
  logic [IDW-1:0]    sel_c;
  logic              tset_c;

  irq_sync_edge #(.W(NSRC)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (src_irq),
    .rise_c (rise_c)
  );

  // Fixed priority: lowest index among enabled pending bits.
  always_comb begin
    any_c = 1'b0;
    sel_c = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (pending[i] && irq_en[i]) begin
        any_c = 1'b1;
        sel_c = IDW'(i);
      end
    end
  end

  always_comb begin
    ack_clr_c = '0;
    if (state == REQ && ExtIAck) begin
      ack_clr_c[irq_id] = 1'b1;
    end
  end

  // Fires once, on the cycle the wait counter steps onto TIMEOUT.
  assign tset_c = (state == REQ) && !ExtIAck && (tcnt != TCNT_MAX) &&
                  (((TCNT_W + 1)'(tcnt) + (TCNT_W + 1)'(1)) == TCNT_HIT);

  assign busy = (state != IDLE);

  // A fresh edge outranks the ack clear so a re-raise during service is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~ack_clr_c) | (rise_c & irq_en);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_flag <= 1'b0;
    end else if (tset_c) begin
      timeout_flag <= 1'b1;
    end else if (timeout_clr) begin
      timeout_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ExtIRQ <= 1'b0;
      irq_id <= '0;
      tcnt   <= '0;
      hcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_c) begin
            irq_id <= sel_c;
            ExtIRQ <= 1'b1;
            tcnt   <= '0;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ExtIAck) begin
            ExtIRQ <= 1'b0;
            state  <= ACK;
          end else if (tcnt != TCNT_MAX) begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        ACK: begin
          // A level ack must drop before anything new can be acknowledged.
          if (!ExtIAck) begin
            if (HOLDOFF == 0) begin
              state <= IDLE;
            end else begin
              hcnt  <= HOLD_INIT;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (hcnt == '0) begin
            state <= IDLE;
          end else begin
            hcnt <= hcnt - HCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Bench for ext_irq_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_ext_irq_ctrl;

  localparam int unsigned NSRC    = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned HOLDOFF = 2;

  logic            clk;
  logic            reset;
  logic [NSRC-1:0] src_irq;
  logic [NSRC-1:0] irq_en;
  logic            ext_irq;
  logic            ext_iack;
  logic [IDW-1:0]  irq_id;
  logic [NSRC-1:0] pending;
  logic            busy;
  logic            timeout_flag;
  logic            timeout_clr;

  int checks;
  int errors;

  ext_irq_ctrl #(
    .NSRC(NSRC), .IDW(IDW), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_irq      (src_irq),
    .irq_en       (irq_en),
    .ExtIRQ       (ext_irq),
    .ExtIAck      (ext_iack),
    .irq_id       (irq_id),
    .pending      (pending),
    .busy         (busy),
    .timeout_flag (timeout_flag),
    .timeout_clr  (timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request is either being presented, awaiting ack release,
  // or serving out a number of enforced idle cycles before the next grant.
  logic [NSRC-1:0] h1, h2, h3;
  logic [NSRC-1:0] m_pend, m_rise, m_clr;
  logic [IDW-1:0]  m_id;
  bit              m_irq, m_rel, m_flag, m_fset;
  int              m_gap, m_wait;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_pend = '0; m_id = '0;
      m_irq = 0; m_rel = 0; m_flag = 0;
      m_gap = 0; m_wait = 0;
    end else begin
      m_rise = h2 & ~h3;
      m_clr  = '0;
      m_fset = 0;
      if (m_irq) begin
        if (ext_iack) begin
          m_clr[m_id] = 1'b1;
          m_irq = 0;
          m_rel = 1;
        end else if (m_wait < 255) begin
          m_wait++;
          if (m_wait == int'(TIMEOUT)) m_fset = 1;
        end
      end else if (m_rel) begin
        if (!ext_iack) begin
          m_rel = 0;
          m_gap = int'(HOLDOFF);
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else begin
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
          if (m_pend[i] && irq_en[i]) begin
            m_irq  = 1;
            m_id   = IDW'(i);
            m_wait = 0;
          end
        end
      end
      m_pend = (m_pend & ~m_clr) | (m_rise & irq_en);
      if (m_fset) m_flag = 1;
      else if (timeout_clr) m_flag = 0;
      h3 = h2; h2 = h1; h1 = src_irq;
    end
  end

  // Every cycle: all outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    check("ExtIRQ", 32'(ext_irq), 32'(m_irq));
    check("irq_id", 32'(irq_id), 32'(m_id));
    check("pending", 32'(pending), 32'(m_pend));
    check("busy", 32'(busy), 32'(m_irq || m_rel || (m_gap > 0)));
    check("timeout_flag", 32'(timeout_flag), 32'(m_flag));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; src_irq = '0; irq_en = '1; ext_iack = 1'b0; timeout_clr = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    step(2);
    check("t1_reset_pending", 32'(pending), 32'h0);
    check("t1_reset_busy", 32'(busy), 32'h0);
    check("t1_reset_irq", 32'(ext_irq), 32'h0);

    // Single source 2 pulse with a two-cycle ack.
    src_irq = 4'b0100;
    step(3);
    check("t2_irq_before_3rd", 32'(ext_irq), 32'h0);
    step(1);
    check("t2_irq_up", 32'(ext_irq), 32'h1);
    check("t2_id", 32'(irq_id), 32'h2);
    src_irq = '0; ext_iack = 1'b1;
    step(1);
    check("t2_irq_dropped", 32'(ext_irq), 32'h0);
    check("t2_pend_cleared", 32'(pending), 32'h0);
    step(1);
    ext_iack = 1'b0;
    step(1);
    check("t2_hold_busy1", 32'(busy), 32'h1);
    step(1);
    check("t2_hold_busy2", 32'(busy), 32'h1);
    step(1);
    check("t2_idle", 32'(busy), 32'h0);

    // Sources 1 and 3 together: 1 first, 3 after the hold-off gap.
    src_irq = 4'b1010;
    step(4);
    check("t3_first_irq", 32'(ext_irq), 32'h1);
    check("t3_first_id", 32'(irq_id), 32'h1);
    ext_iack = 1'b1;
    step(1);
    ext_iack = 1'b0; src_irq = '0;
    step(1);
    step(2);
    check("t3_gap_irq", 32'(ext_irq), 32'h0);
    step(1);
    check("t3_second_irq", 32'(ext_irq), 32'h1);
    check("t3_second_id", 32'(irq_id), 32'h3);
    ext_iack = 1'b1;
    step(1);
    ext_iack = 1'b0;
    step(4);
    check("t3_idle", 32'(busy), 32'h0);

    // Disabled source toggling leaves nothing pending.
    irq_en = 4'b1110;
    repeat (5) begin
      src_irq[0] = 1'b1; step(3);
      src_irq[0] = 1'b0; step(3);
    end
    check("t4_pending", 32'(pending), 32'h0);
    check("t4_irq", 32'(ext_irq), 32'h0);
    irq_en = '1;

    // Unanswered request trips the timeout flag but stays up.
    src_irq = 4'b0001;
    step(4);
    check("t5_irq_up", 32'(ext_irq), 32'h1);
    src_irq = '0;
    step(7);
    check("t5_flag_early", 32'(timeout_flag), 32'h0);
    step(1);
    check("t5_flag_set", 32'(timeout_flag), 32'h1);
    check("t5_irq_held", 32'(ext_irq), 32'h1);
    timeout_clr = 1'b1;
    step(1);
    timeout_clr = 1'b0;
    check("t5_flag_clr", 32'(timeout_flag), 32'h0);
    ext_iack = 1'b1;
    step(1);
    check("t5_ack_irq", 32'(ext_irq), 32'h0);
    ext_iack = 1'b0;
    step(4);
    check("t5_idle", 32'(busy), 32'h0);

    // Re-raise of source 2 lands in the same cycle as its ack.
    src_irq = 4'b0100;
    step(4);
    check("t6_irq_up", 32'(ext_irq), 32'h1);
    check("t6_id", 32'(irq_id), 32'h2);
    src_irq = '0;
    step(3);
    src_irq = 4'b0100;
    step(2);
    ext_iack = 1'b1;
    step(1);
    check("t6_pend_kept", 32'(pending), 32'h4);
    check("t6_irq_low", 32'(ext_irq), 32'h0);
    ext_iack = 1'b0; src_irq = '0;
    step(3);
    check("t6_gap_irq", 32'(ext_irq), 32'h0);
    step(1);
    check("t6_second_irq", 32'(ext_irq), 32'h1);
    check("t6_second_id", 32'(irq_id), 32'h2);
    ext_iack = 1'b1;
    step(1);
    ext_iack = 1'b0;
    step(4);

    // Reset asserted mid-request drops ExtIRQ without a clock edge.
    src_irq = 4'b0001;
    step(4);
    check("t1_req_up", 32'(ext_irq), 32'h1);
    reset = 1'b0;
    #1;
    check("t1_async_irq", 32'(ext_irq), 32'h0);
    check("t1_async_pending", 32'(pending), 32'h0);
    src_irq = '0;
    step(2);
    reset = 1'b1;
    step(2);
    check("t1_post_busy", 32'(busy), 32'h0);
    check("t1_post_pending", 32'(pending), 32'h0);

    // Random traffic against the model.
    repeat (3000) begin
      for (int b = 0; b < int'(NSRC); b++) begin
        if ($urandom_range(7) == 0) src_irq[b] = ~src_irq[b];
      end
      if ($urandom_range(63) == 0) irq_en = NSRC'($urandom);
      if (ext_iack) ext_iack = ($urandom_range(1) == 0);
      else if (ext_irq) ext_iack = ($urandom_range(3) == 0);
      else ext_iack = ($urandom_range(15) == 0);
      timeout_clr = ($urandom_range(31) == 0);
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
